pacman_motion: RTL and testbench

PACMAN_MOTION -- requirements
Module: pacman_motion

---
 rtl/pacman_motion.sv | 195 +++++++++++++++++++
 tb/tb_pacman_motion.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion.sv
// pacman_motion: tile-grid sprite motion with a four-neighbour wall lookup.
// Ports: Clk/Reset (async, active-high); frame_tick + direction request one
//   pixel step; pacman_x/pacman_y give the registered position;
//   adjacent_walls/walls_valid report the walls around the current tile;
//   wall_rd/wall_addr/wall_data form the wall-map read port, with data one
//   cycle after the strobe.
// Optional feature: define TUNNEL_WRAP_EN to wrap columns across the maze
//   edge (rows never wrap).
module pacman_motion #(
    parameter int START_X   = 208,
    parameter int START_Y   = 368,
    parameter int MAZE_COLS = 28,
    parameter int MAZE_ROWS = 31
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [2:0] direction,
    output logic [9:0] pacman_x,
    output logic [9:0] pacman_y,
    output logic [3:0] adjacent_walls,
    output logic       walls_valid,
    output logic       wall_rd,
    output logic [9:0] wall_addr,
    input  logic       wall_data
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] RQ_U = 4'd1;
    localparam logic [3:0] CP_U = 4'd2;
    localparam logic [3:0] RQ_R = 4'd3;
    localparam logic [3:0] CP_R = 4'd4;
    localparam logic [3:0] RQ_D = 4'd5;
    localparam logic [3:0] CP_D = 4'd6;
    localparam logic [3:0] RQ_L = 4'd7;
    localparam logic [3:0] CP_L = 4'd8;

`ifdef TUNNEL_WRAP_EN
    localparam logic [9:0] LAST_X = 10'((MAZE_COLS - 1) * 16);
`endif

    logic [3:0] state;
    logic [3:0] state_nx;
    logic       start;
    logic       pending;
    logic [2:0] shadow;

    logic [1:0] ld;
    logic       is_rq;
    logic       is_cp;

    // Lookup sequencer: each request phase is followed by its capture phase.
    always_comb begin
        state_nx = state;
        ld       = 2'd0;
        is_rq    = 1'b0;
        is_cp    = 1'b0;
        unique case (state)
            IDLE: state_nx = start ? RQ_U : IDLE;
            RQ_U: begin is_rq = 1'b1; ld = 2'd0; state_nx = CP_U; end
            CP_U: begin is_cp = 1'b1; ld = 2'd0; state_nx = RQ_R; end
            RQ_R: begin is_rq = 1'b1; ld = 2'd1; state_nx = CP_R; end
            CP_R: begin is_cp = 1'b1; ld = 2'd1; state_nx = RQ_D; end
            RQ_D: begin is_rq = 1'b1; ld = 2'd2; state_nx = CP_D; end
            CP_D: begin is_cp = 1'b1; ld = 2'd2; state_nx = RQ_L; end
            RQ_L: begin is_rq = 1'b1; ld = 2'd3; state_nx = CP_L; end
            CP_L: begin is_cp = 1'b1; ld = 2'd3; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    // Neighbour tile; position is frozen for the whole lookup, so the
    // request and capture phases of one direction see the same neighbour.
    // Underflow of 0-1 yields 7'h7F, which falls outside the maze.
    logic [6:0] col;
    logic [6:0] row;
    logic [6:0] nc;
    logic [6:0] nr;
    logic       in_range;
    logic       cap;

    assign col = {1'b0, pacman_x[9:4]};
    assign row = {1'b0, pacman_y[9:4]};

    always_comb begin
        nc = col;
        nr = row;
        unique case (ld)
            2'd0:    nr = row - 7'd1;
            2'd1:    nc = col + 7'd1;
            2'd2:    nr = row + 7'd1;
            default: nc = col - 7'd1;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (nc == 7'h7F)
            nc = 7'(MAZE_COLS - 1);
        else if (nc == 7'(MAZE_COLS))
            nc = 7'd0;
`endif
    end

    assign in_range  = (nr < 7'(MAZE_ROWS)) && (nc < 7'(MAZE_COLS));
    assign wall_rd   = is_rq && in_range;
    assign wall_addr = wall_rd ? 10'(nr) * 10'(MAZE_COLS) + 10'(nc) : 10'd0;
    // Off-maze neighbours read as walls without touching the map.
    assign cap       = in_range ? wall_data : 1'b1;

    // Step logic. A tick is only applied once the lookup of the current
    // tile is finished; until then it parks in the one-deep pending flag.
    logic       aligned;
    logic       free;
    logic       apply;
    logic       blocked;
    logic       move;
    logic       commit;
    logic [9:0] nx;
    logic [9:0] ny;

    assign aligned = (pacman_x[3:0] == 4'd0) && (pacman_y[3:0] == 4'd0);
    assign free    = (state == IDLE) && !start;
    assign apply   = free && (frame_tick || pending);
    assign blocked = aligned && walls_valid && adjacent_walls[direction[1:0]];
    assign move    = apply && direction[2] && !blocked;

    always_comb begin
        nx = pacman_x;
        ny = pacman_y;
        unique case (direction[1:0])
            2'd0: ny = pacman_y - 10'd1;
            2'd1: begin
                nx = pacman_x + 10'd1;
`ifdef TUNNEL_WRAP_EN
                if (pacman_x == LAST_X)
                    nx = 10'd0;
`endif
            end
            2'd2: ny = pacman_y + 10'd1;
            default: begin
                nx = pacman_x - 10'd1;
`ifdef TUNNEL_WRAP_EN
                if (pacman_x == 10'd0)
                    nx = LAST_X;
`endif
            end
        endcase
    end

    assign commit = move && (nx[3:0] == 4'd0) && (ny[3:0] == 4'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            start          <= 1'b1;
            pending        <= 1'b0;
            pacman_x       <= 10'(START_X);
            pacman_y       <= 10'(START_Y);
            shadow         <= 3'b111;
            adjacent_walls <= 4'b1111;
            walls_valid    <= 1'b0;
        end else begin
            state <= state_nx;

            if ((state == IDLE) && start)
                start <= 1'b0;
            else if (commit)
                start <= 1'b1;

            if (free)
                pending <= 1'b0;
            else if (frame_tick)
                pending <= 1'b1;

            if (move) begin
                pacman_x <= nx;
                pacman_y <= ny;
            end

            if (commit)
                walls_valid <= 1'b0;
            else if (state == CP_L)
                walls_valid <= 1'b1;

            // Left is captured last, so all four bits publish together.
            if (is_cp) begin
                unique case (ld)
                    2'd0:    shadow[0] <= cap;
                    2'd1:    shadow[1] <= cap;
                    2'd2:    shadow[2] <= cap;
                    default: adjacent_walls <= {cap, shadow};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pacman_motion.sv
// tb_pacman_motion: self-checking bench for pacman_motion with a
// behavioural position/wall model, directed cases and random play.
module tb_pacman_motion;

    localparam int C = 28;
    localparam int R = 31;
    localparam int SX = 208;
    localparam int SY = 368;
`ifdef TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [9:0] LASTX = 10'((C - 1) * 16);

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] dir = 3'b000;
    logic       wall_data = 1'b0;
    logic [9:0] pacman_x, pacman_y, wall_addr;
    logic [3:0] aw;
    logic       wv, wrd;

    logic       Reset2 = 1'b1;
    logic       tick2 = 1'b0;
    logic [2:0] dir2 = 3'b000;
    logic       wall_data2 = 1'b0;
    logic [9:0] x2, y2, wall_addr2;
    logic [3:0] aw2;
    logic       wv2, wrd2;

    int n_chk = 0;
    int n_fail = 0;

    bit map [0:1023];
    int seen[$];
    int seen2[$];

    always #5 Clk = ~Clk;

    pacman_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick), .direction(dir),
        .pacman_x(pacman_x), .pacman_y(pacman_y), .adjacent_walls(aw),
        .walls_valid(wv), .wall_rd(wrd), .wall_addr(wall_addr),
        .wall_data(wall_data)
    );

    pacman_motion #(.START_X(0), .START_Y(224)) dut2 (
        .Clk(Clk), .Reset(Reset2), .frame_tick(tick2), .direction(dir2),
        .pacman_x(x2), .pacman_y(y2), .adjacent_walls(aw2),
        .walls_valid(wv2), .wall_rd(wrd2), .wall_addr(wall_addr2),
        .wall_data(wall_data2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] mx, my;
    logic [3:0] mw;
    bit         mv, mpend;
    int         busy;
    int         expq[$];

    function automatic bit nb(input logic [9:0] px, input logic [9:0] py,
                              input int d, output int addr);
        int c, r;
        c = int'(px[9:4]);
        r = int'(py[9:4]);
        case (d)
            0: r = r - 1;
            1: c = c + 1;
            2: r = r + 1;
            default: c = c - 1;
        endcase
        if (WRAP) c = (c + C) % C;
        addr = r * C + c;
        return (r >= 0 && r < R && c >= 0 && c < C);
    endfunction

    task automatic queue_lookup();
        int a;
        expq.delete();
        for (int d = 0; d < 4; d++)
            if (nb(mx, my, d, a)) expq.push_back(a);
    endtask

    task automatic model_reset();
        mx = 10'(SX); my = 10'(SY);
        mw = 4'hF; mv = 0; mpend = 0;
        busy = 9;
        queue_lookup();
    endtask

    task automatic model_step();
        logic [1:0] d;
        if (!dir[2]) return;
        d = dir[1:0];
        if (mx[3:0] == 0 && my[3:0] == 0 && mv && mw[d]) return;
        case (d)
            2'd0: my = my - 10'd1;
            2'd1: mx = (WRAP && mx == LASTX) ? 10'd0 : mx + 10'd1;
            2'd2: my = my + 10'd1;
            default: mx = (WRAP && mx == 10'd0) ? LASTX : mx - 10'd1;
        endcase
        if (mx[3:0] == 0 && my[3:0] == 0) begin
            mv = 0;
            busy = 9;
            queue_lookup();
        end
    endtask

    // A lookup occupies nine edges after it is triggered; ticks in that
    // window collapse into one pending step.
    always @(posedge Clk or posedge Reset) begin
        int a;
        if (Reset) begin
            model_reset();
        end else if (busy > 0) begin
            if (tick) mpend = 1;
            busy--;
            if (busy == 0) begin
                for (int d = 0; d < 4; d++)
                    mw[d] = nb(mx, my, d, a) ? map[a] : 1'b1;
                mv = 1;
                check("rd_drain", expq.size(), 0);
            end
        end else if (tick || mpend) begin
            mpend = 0;
            model_step();
        end
    end

    // ---------------- wall-map responders ----------------
    logic       prd = 0, prd2 = 0;
    logic [9:0] paddr = 0, paddr2 = 0;

    always @(negedge Clk) begin
        wall_data = prd ? map[paddr] : 1'($urandom);
        prd = wrd;
        paddr = wall_addr;
        wall_data2 = prd2 ? map[paddr2] : 1'($urandom);
        prd2 = wrd2;
        paddr2 = wall_addr2;
        if (wrd2) seen2.push_back(int'(wall_addr2));
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (wrd) begin
            seen.push_back(int'(wall_addr));
            if (expq.size() == 0) check("rd_extra", int'(wall_addr), -1);
            else check("rd_addr", int'(wall_addr), expq.pop_front());
        end
        if (!Reset) begin
            check("x", int'(pacman_x), int'(mx));
            check("y", int'(pacman_y), int'(my));
            check("walls", int'(aw), int'(mw));
            check("valid", int'(wv), int'(mv));
        end
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1;
        seen.delete();
        cyc();
        cyc();
        Reset = 0;
    endtask

    task automatic pulse();
        tick = 1;
        cyc();
        tick = 0;
    endtask

    initial begin
        int lit[4];
        lit[0] = 629; lit[1] = 658; lit[2] = 685; lit[3] = 656;
        for (int i = 0; i < 1024; i++) map[i] = 0;
        @(negedge Clk);

        // Reset values and first lookup of the start tile.
        Reset = 1; seen.delete();
        cyc(); cyc();
        check("rst_x", int'(pacman_x), 208);
        check("rst_y", int'(pacman_y), 368);
        check("rst_walls", int'(aw), 15);
        check("rst_valid", int'(wv), 0);
        check("rst_rd", int'(wrd), 0);
        check("rst_addr", int'(wall_addr), 0);
        Reset = 0;
        // lookup starts on the first edge, then eight more complete it
        repeat (8) cyc();
        check("valid_early", int'(wv), 0);
        cyc();
        check("valid_up", int'(wv), 1);
        check("walls_zero", int'(aw), 0);
        check("rd_count", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            check("rd_order", seen.size() > i ? seen[i] : -1, lit[i]);

        // Wall above the start tile blocks upward ticks.
        map[629] = 1;
        dir = 3'b100;
        do_reset();
        repeat (9) cyc();
        repeat (3) begin
            pulse();
            repeat (5) cyc();
        end
        check("blk_y", int'(pacman_y), 368);
        check("blk_x", int'(pacman_x), 208);
        check("blk_walls", int'(aw), 1);
        map[629] = 0;

        // Sixteen right steps reach the next tile and restart the lookup.
        dir = 3'b101;
        do_reset();
        repeat (12) cyc();
        for (int i = 0; i < 16; i++) begin
            pulse();
            if (i < 15) repeat (19) cyc();
        end
        check("step16_x", int'(pacman_x), 224);
        check("step16_valid", int'(wv), 0);
        // Reset during the down-capture phase of that lookup.
        repeat (6) cyc();
        check("mid_valid", int'(wv), 0);
        Reset = 1;
        seen.delete();
        #1;
        check("abort_x", int'(pacman_x), 208);
        check("abort_walls", int'(aw), 15);
        check("abort_valid", int'(wv), 0);
        check("abort_rd", int'(wrd), 0);
        cyc();
        Reset = 0;
        repeat (9) cyc();
        check("relook_valid", int'(wv), 1);
        check("relook_count", seen.size(), 4);
        check("relook_left", seen.size() > 3 ? seen[3] : -1, 656);

        // Ticks during a lookup: one is held, the second dropped.
        dir = 3'b101;
        do_reset();
        repeat (3) cyc();
        pulse();
        cyc();
        pulse();
        repeat (3) cyc();
        check("pend_hold_x", int'(pacman_x), 208);
        check("pend_valid", int'(wv), 1);
        cyc();
        check("pend_apply_x", int'(pacman_x), 209);
        repeat (10) cyc();
        check("pend_once_x", int'(pacman_x), 209);

        // Left step from column 0 on a second instance.
        Reset2 = 1; seen2.delete();
        cyc(); cyc();
        Reset2 = 0;
        repeat (10) cyc();
        dir2 = 3'b111;
        tick2 = 1;
        cyc();
        tick2 = 0;
`ifdef TUNNEL_WRAP_EN
        check("wrap_x", int'(x2), 432);
        check("wrap_left_addr", seen2.size() > 3 ? seen2[3] : -1, 419);
`else
        check("edge_x", int'(x2), 0);
        check("edge_left_wall", int'(aw2[3]), 1);
        check("edge_rd_count", seen2.size(), 3);
`endif

        // Random play on a random maze.
        for (int i = 0; i < 1024; i++) map[i] = ($urandom_range(0, 99) < 25);
        dir = 3'b101;
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            tick = ($urandom_range(0, 2) == 0);
            if (mx[3:0] == 0 && my[3:0] == 0 && $urandom_range(0, 5) == 0)
                dir = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1999) == 0) begin
                tick = 0;
                do_reset();
            end else begin
                cyc();
            end
        end
        tick = 0;
        repeat (12) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
